diag_log_arbiter: RTL

DIAG_LOG_ARBITER -- requirements
Module: diag_log_arbiter

---
 rtl/diag_log_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/diag_log_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | diag_log_arbiter : round-robin arbiter funnelling per-requester          |
// |                    diagnostic samples into one shared I2C logger.         |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module diag_log_arbiter #(
  parameter int N_REQ    = 4,
  parameter int PAGE_W   = 8,
  parameter int VAL_W    = 16,
  parameter int BUSY_TMO = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_new,
  input  logic [N_REQ*PAGE_W-1:0] req_page,
  input  logic [N_REQ*VAL_W-1:0]  req_value,
  input  logic                    i2c_busy,
  output logic                    log_new,
  output logic [PAGE_W-1:0]       log_page,
  output logic [VAL_W-1:0]        log_value,
  output logic [2:0]              log_src,
  output logic [N_REQ-1:0]        pending,
  output logic [15:0]             drop_cnt,
  output logic [15:0]             tmo_cnt
);

  localparam int TMO_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [2:0]        rr_ptr_q,    rr_ptr_d;
  logic [TMO_W-1:0]  timer_q,     timer_d;
  logic              log_new_q,   log_new_d;
  logic [PAGE_W-1:0] log_page_q,  log_page_d;
  logic [VAL_W-1:0]  log_value_q, log_value_d;
  logic [2:0]        log_src_q,   log_src_d;
  logic [N_REQ-1:0]  pending_q,   pending_d;
  logic [15:0]       drop_cnt_q,  drop_cnt_d;
  logic [15:0]       tmo_cnt_q,   tmo_cnt_d;
  logic [PAGE_W-1:0] page_q  [N_REQ];
  logic [PAGE_W-1:0] page_d  [N_REQ];
  logic [VAL_W-1:0]  value_q [N_REQ];
  logic [VAL_W-1:0]  value_d [N_REQ];

  logic [N_REQ-1:0]  win_oh;
  logic [2:0]        win_idx;
  logic              win_found;
  logic [3:0]        cand;
  logic              grant;
  logic              tmo_hit;
  logic [3:0]        drop_inc;
  logic [16:0]       drop_sum;
  logic [PAGE_W-1:0] sel_page;
  logic [VAL_W-1:0]  sel_value;

  // Round-robin search: first pending slot at or above rr_ptr_q, wrapping.
  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= 4'(N_REQ)) begin
        cand = cand - 4'(N_REQ);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!win_found && (cand == 4'(i)) && pending_q[i]) begin
          win_found = 1'b1;
          win_oh[i] = 1'b1;
          win_idx   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_page  = '0;
    sel_value = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        sel_page  = page_q[i];
        sel_value = value_q[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    log_new_d   = 1'b0;
    log_page_d  = log_page_q;
    log_value_d = log_value_q;
    log_src_d   = log_src_q;
    grant       = 1'b0;
    tmo_hit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found && !i2c_busy) begin
          grant       = 1'b1;
          log_new_d   = 1'b1;
          log_page_d  = sel_page;
          log_value_d = sel_value;
          log_src_d   = win_idx;
          rr_ptr_d    = (win_idx == 3'(N_REQ - 1)) ? 3'd0 : win_idx + 3'd1;
          timer_d     = '0;
          state_d     = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (i2c_busy) begin
          state_d = ST_WAIT_LO;
        end else if (timer_q == TMO_W'(BUSY_TMO - 1)) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!i2c_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A strobe on the slot being granted this cycle refills it without a drop:
  // the grant already took the old contents.
  always_comb begin
    pending_d = pending_q;
    page_d    = page_q;
    value_d   = value_q;
    drop_inc  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_new[i]) begin
        page_d[i]    = req_page[i*PAGE_W +: PAGE_W];
        value_d[i]   = req_value[i*VAL_W +: VAL_W];
        pending_d[i] = 1'b1;
        if (pending_q[i] && !(grant && win_oh[i])) begin
          drop_inc = drop_inc + 4'd1;
        end
      end else if (grant && win_oh[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_inc);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    tmo_cnt_d  = (tmo_hit && (tmo_cnt_q != 16'hFFFF)) ? tmo_cnt_q + 16'd1 : tmo_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      timer_q     <= '0;
      log_new_q   <= 1'b0;
      log_page_q  <= '0;
      log_value_q <= '0;
      log_src_q   <= '0;
      pending_q   <= '0;
      drop_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      page_q      <= '{default: '0};
      value_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      log_new_q   <= log_new_d;
      log_page_q  <= log_page_d;
      log_value_q <= log_value_d;
      log_src_q   <= log_src_d;
      pending_q   <= pending_d;
      drop_cnt_q  <= drop_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      page_q      <= page_d;
      value_q     <= value_d;
    end
  end

  assign log_new   = log_new_q;
  assign log_page  = log_page_q;
  assign log_value = log_value_q;
  assign log_src   = log_src_q;
  assign pending   = pending_q;
  assign drop_cnt  = drop_cnt_q;
  assign tmo_cnt   = tmo_cnt_q;

endmodule
`default_nettype wire
